// File: rtl/gzip_trailer_checker.sv
`default_nettype none
// ============================================================================
// Module   : gzip_trailer_checker
// Purpose  : Computes CRC32/ISIZE over inflated payload bytes and checks them
//            against the 8-byte gzip trailer that follows.
// Revision : 1.0  initial release
// ============================================================================
module gzip_trailer_checker #(
    parameter logic [31:0] POLY       = 32'hEDB88320,
    parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pay_in,
    input  logic        pay_valid_in,
    input  logic [7:0]  trl_in,
    input  logic        trl_valid_in,
    output logic [31:0] crc32_out,
    output logic [31:0] isize_out,
    output logic        done_out,
    output logic        crc_ok_out,
    output logic        isize_ok_out,
    output logic        proto_err_out
);

    localparam logic [1:0] S_DATA    = 2'd0;
    localparam logic [1:0] S_TRAILER = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_crc;
    logic [31:0] r_isize;
    logic [63:0] r_trl;
    logic [2:0]  r_cnt;
    logic        r_done;
    logic        r_crc_ok;
    logic        r_isize_ok;
    logic        r_proto_err;

    logic [31:0] w_crc_next;
    logic [63:0] w_trl_next;

    // Reflected CRC32, one full byte per clock (eight unrolled shift steps).
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] v;
        v = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            v = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
        end
        return v;
    endfunction

    always_comb begin
        w_crc_next = crc_byte(r_crc, pay_in);
        w_trl_next = r_trl;
        w_trl_next[{r_cnt, 3'b000} +: 8] = trl_in;
    end

    assign crc32_out     = r_crc ^ CRC_XOROUT;
    assign isize_out     = r_isize;
    assign done_out      = r_done;
    assign crc_ok_out    = r_crc_ok;
    assign isize_ok_out  = r_isize_ok;
    assign proto_err_out = r_proto_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_DATA;
            r_crc       <= CRC_INIT;
            r_isize     <= 32'd0;
            r_trl       <= 64'd0;
            r_cnt       <= 3'd0;
            r_done      <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_isize_ok  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                S_DATA: begin
                    if (pay_valid_in) begin
                        r_crc   <= w_crc_next;
                        r_isize <= r_isize + 32'd1;
                    end
                    if (trl_valid_in) begin
                        r_trl   <= w_trl_next;
                        r_cnt   <= 3'd1;
                        r_state <= S_TRAILER;
                    end
                end
                S_TRAILER: begin
                    if (pay_valid_in) begin
                        r_proto_err <= 1'b1;
                    end
                    if (trl_valid_in) begin
                        r_trl <= w_trl_next;
                        r_cnt <= r_cnt + 3'd1;
                        // CRC/ISIZE are frozen here, so compare against the
                        // trailer including the byte arriving this cycle.
                        if (r_cnt == 3'd7) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_crc_ok   <= (w_trl_next[31:0] == crc32_out);
                            r_isize_ok <= (w_trl_next[63:32] == r_isize);
                        end
                    end
                end
                S_DONE: begin
                    if (pay_valid_in) begin
                        r_proto_err <= 1'b1;
                    end
                end
                default: r_state <= S_DATA;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gzip_trailer_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gzip_trailer_checker
// Purpose  : Scoreboard bench for gzip_trailer_checker using directed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_gzip_trailer_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pay_in = 8'd0;
    logic        pay_valid_in = 1'b0;
    logic [7:0]  trl_in = 8'd0;
    logic        trl_valid_in = 1'b0;
    logic [31:0] crc32_out;
    logic [31:0] isize_out;
    logic        done_out;
    logic        crc_ok_out;
    logic        isize_ok_out;
    logic        proto_err_out;

    gzip_trailer_checker dut (
        .clk          (clk),
        .rst          (rst),
        .pay_in       (pay_in),
        .pay_valid_in (pay_valid_in),
        .trl_in       (trl_in),
        .trl_valid_in (trl_valid_in),
        .crc32_out    (crc32_out),
        .isize_out    (isize_out),
        .done_out     (done_out),
        .crc_ok_out   (crc_ok_out),
        .isize_ok_out (isize_ok_out),
        .proto_err_out(proto_err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] crc;
        logic [31:0] isize;
        logic        crc_ok;
        logic        isize_ok;
        logic        perr;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc_cnt = 0;
    int   checks  = 0;
    int   errors  = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: each rising done_out consumes one expected trailer result.
    always @(negedge clk) begin
        if (done_out === 1'b1 && prev_done !== 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d required none", cyc_cnt);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", 64'(cyc_cnt), 64'(e.cyc));
                chk("crc32_out",  {32'd0, crc32_out}, {32'd0, e.crc});
                chk("isize_out",  {32'd0, isize_out}, {32'd0, e.isize});
                chk("crc_ok",     {63'd0, crc_ok_out}, {63'd0, e.crc_ok});
                chk("isize_ok",   {63'd0, isize_ok_out}, {63'd0, e.isize_ok});
                chk("proto_err",  {63'd0, proto_err_out}, {63'd0, e.perr});
            end
        end
        prev_done = done_out;
    end

    task automatic step(input logic pv, input logic [7:0] pd, input logic tv, input logic [7:0] td);
        pay_valid_in = pv;
        pay_in       = pd;
        trl_valid_in = tv;
        trl_in       = td;
        @(posedge clk);
        #1;
        pay_valid_in = 1'b0;
        trl_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 8'd0, 1'b0, 8'd0);
        rst = 1'b0;
    endtask

    task automatic send_str(input string s, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            step(1'b1, s[i], 1'b0, 8'd0);
            if (gaps && (i % 3 == 1)) step(1'b0, 8'd0, 1'b0, 8'd0);
        end
    endtask

    task automatic send_fill(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) step(1'b1, b, 1'b0, 8'd0);
    endtask

    task automatic send_trl(input logic [63:0] t, input int lo, input int hi, input exp_t e);
        for (int i = lo; i <= hi; i++) begin
            if (i == 7) begin
                e.cyc = cyc_cnt + 1;
                q.push_back(e);
            end
            step(1'b0, 8'd0, 1'b1, t[i*8 +: 8]);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] c, input logic [31:0] n,
                                input logic co, input logic io, input logic pe);
        exp_t e;
        e.crc = c; e.isize = n; e.crc_ok = co; e.isize_ok = io; e.perr = pe; e.cyc = 0;
        return e;
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, "_crc"},   {32'd0, crc32_out}, 64'd0);
        chk({tag, "_isize"}, {32'd0, isize_out}, 64'd0);
        chk({tag, "_outs"},  {60'd0, done_out, crc_ok_out, isize_ok_out, proto_err_out}, 64'd0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        chk_reset_state("reset");

        // "0123456789"
        send_str("0123456789", 1'b0);
        send_trl(64'h0000000A_A684C7C6, 0, 7, mk(32'hA684C7C6, 32'd10, 1'b1, 1'b1, 1'b0));
        step(1'b0, 8'd0, 1'b1, 8'hFF);
        chk("done_hold", {63'd0, done_out}, 64'd1);
        chk("crc_ok_hold", {63'd0, crc_ok_out}, 64'd1);

        // 32 x 00, then 32 x FF
        do_reset();
        send_fill(8'h00, 32);
        send_trl(64'h00000020_190A55AD, 0, 7, mk(32'h190A55AD, 32'd32, 1'b1, 1'b1, 1'b0));
        do_reset();
        send_fill(8'hFF, 32);
        send_trl(64'h00000020_FF6CAB0B, 0, 7, mk(32'hFF6CAB0B, 32'd32, 1'b1, 1'b1, 1'b0));

        // Pangram with gaps, correct then corrupted trailer
        do_reset();
        send_str("The quick brown fox jumps over the lazy dog", 1'b1);
        send_trl(64'h0000002B_414FA339, 0, 7, mk(32'h414FA339, 32'd43, 1'b1, 1'b1, 1'b0));
        do_reset();
        send_str("The quick brown fox jumps over the lazy dog", 1'b1);
        send_trl(64'h0000002B_414FA338, 0, 7, mk(32'h414FA339, 32'd43, 1'b0, 1'b1, 1'b0));

        // 00..1F with last payload byte sharing a cycle with trailer byte 0
        do_reset();
        for (int i = 0; i < 31; i++) step(1'b1, 8'(i), 1'b0, 8'd0);
        step(1'b1, 8'h1F, 1'b1, 8'h8A);
        send_trl(64'h00000020_91267E8A, 1, 7, mk(32'h91267E8A, 32'd32, 1'b1, 1'b1, 1'b0));

        // Empty payload
        do_reset();
        send_trl(64'h0, 0, 7, mk(32'h0, 32'd0, 1'b1, 1'b1, 1'b0));

        // Payload byte inside the trailer: ignored, sticky protocol error
        do_reset();
        send_str("0123456789", 1'b0);
        send_trl(64'h0000000A_A684C7C6, 0, 3, mk(32'h0, 32'd0, 1'b0, 1'b0, 1'b0));
        step(1'b1, 8'h55, 1'b0, 8'd0);
        chk("proto_set", {63'd0, proto_err_out}, 64'd1);
        send_trl(64'h0000000A_A684C7C6, 4, 7, mk(32'hA684C7C6, 32'd10, 1'b1, 1'b1, 1'b1));
        step(1'b1, 8'h77, 1'b0, 8'd0);
        chk("proto_sticky", {63'd0, proto_err_out}, 64'd1);
        chk("crc_frozen", {32'd0, crc32_out}, 64'hA684C7C6);
        chk("isize_frozen", {32'd0, isize_out}, 64'd10);

        // Reset after three trailer bytes, with valids asserted during reset
        do_reset();
        send_str("0123456789", 1'b0);
        send_trl(64'h0000000A_A684C7C6, 0, 2, mk(32'h0, 32'd0, 1'b0, 1'b0, 1'b0));
        rst = 1'b1;
        step(1'b1, 8'h11, 1'b1, 8'h22);
        rst = 1'b0;
        chk_reset_state("midrst");

        // Drain: every expected result must have been consumed
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gzip_trailer_checker.md
Name: gzip_trailer_checker

Overview:
- Receive-side counterpart of the GZIP compressor's CRC32/trailer generation.
- Consumes decompressed payload bytes and computes the gzip CRC32 (reflected 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) and ISIZE (byte count mod 2^32).
- Then collects the 8-byte gzip trailer and reports whether the stored CRC32 and ISIZE match the computed values.
- Sits at the output of the inflate datapath, before the host interface.

Parameters:
- POLY, 32'hEDB88320, reflected CRC32 polynomial.
- CRC_INIT, 32'hFFFFFFFF, CRC register value after reset.
- CRC_XOROUT, 32'hFFFFFFFF, XOR applied to form crc32_out.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pay_in  in  8  decompressed payload byte.
- pay_valid_in  in  1  pay_in valid this cycle.
- trl_in  in  8  trailer byte, gzip order: CRC32 LSB first, then ISIZE LSB first.
- trl_valid_in  in  1  trl_in valid this cycle.
- crc32_out  out  32  running finalized CRC (crc_reg ^ CRC_XOROUT).
- isize_out  out  32  running payload byte count.
- done_out  out  1  trailer fully received; comparison results valid.
- crc_ok_out  out  1  stored CRC32 == computed; valid when done_out=1.
- isize_ok_out  out  1  stored ISIZE == computed; valid when done_out=1.
- proto_err_out  out  1  sticky; payload byte seen after trailer started.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - crc_reg=CRC_INIT, so crc32_out=32'h00000000.
  - isize_out=0, trailer shift reg=0, trailer byte count=0.
  - done_out, crc_ok_out, isize_ok_out, proto_err_out = 0.
  - State=S_DATA.
- FSM states: S_DATA, S_TRAILER, S_DONE.
- S_DATA:
  - pay_valid_in=1: crc_reg <= 8-step byte-wise LSB-first update of crc_reg with pay_in; isize_out <= isize_out+1 (wraps 0xFFFFFFFF->0).
  - crc32_out/isize_out reflect the byte on the next cycle (1-cycle latency). One byte per cycle, no backpressure.
  - trl_valid_in=1: capture trailer byte 0 and go to S_TRAILER.
  - pay_valid_in and trl_valid_in in the same cycle: payload byte is accumulated first, the trailer byte is captured in the same cycle, and the state moves to S_TRAILER. The checked CRC/ISIZE include that payload byte.
  - Zero-length payload is legal: expected trailer is 00×8.
- S_TRAILER:
  - Each trl_valid_in byte goes into a 64-bit register at position count*8 (little-endian); count increments.
  - pay_valid_in=1 here: byte ignored (CRC/ISIZE frozen), proto_err_out <= 1 (sticky until rst).
  - On the 8th byte (count 7): go to S_DONE.
- S_DONE:
  - On entry (the cycle after the 8th byte is accepted): done_out=1.
  - crc_ok_out = (trl[31:0]==crc32_out); isize_ok_out = (trl[63:32]==isize_out). Both are registered together with done_out.
  - All outputs hold until rst.
  - Further trl_valid_in is ignored; pay_valid_in sets proto_err_out.
- Gaps (valid=0) are allowed anywhere; state holds.
- rst asserted mid-payload or mid-trailer: on the next edge everything returns to reset values regardless of valid inputs that cycle.
- CRC update is combinational over 8 bits within one cycle; no multi-cycle paths.

Test Plan:
- Payload "0123456789", trailer C6 C7 84 A6 0A 00 00 00 -> crc32_out=A684C7C6, isize_out=10; done_out=1 one cycle after the 8th byte; crc_ok_out=1, isize_ok_out=1, proto_err_out=0.
- rst, then 32×00, trailer AD 55 0A 19 20 00 00 00 -> crc32_out=190A55AD, both ok=1. Then 32×FF with trailer 0B AB 6C FF 20 00 00 00 -> FF6CAB0B, both ok=1.
- rst, "The quick brown fox jumps over the lazy dog" with valid gaps, trailer 39 A3 4F 41 2B 00 00 00 -> 414FA339, isize 43; corrupt byte 0 to 38 -> crc_ok_out=0, isize_ok_out=1.
- rst, bytes 00..1F where the last payload byte shares a cycle with trailer byte 0 (8A 7E 26 91 20 00 00 00) -> 91267E8A counted with 32 bytes, both ok=1. Empty payload with 00×8 -> both ok=1.
- Payload byte during S_TRAILER -> ignored, proto_err_out=1 and stays 1. rst asserted after 3 trailer bytes -> next cycle all outputs are at reset values, crc32_out=0.
